vector_mem_seq: RTL
===================

Name: vector_mem_seq

Overview:
- Memory-access sequencer for the 6-lane SIMD pipeline.
- Serializes one vector load or store (R lanes of N bits) into R single-lane data-memory transactions with a req/ack handshake.
- Holds the pipeline stalled while it runs, and assembles the loaded lanes into one vector for write-back.
- Sits between the execute stage (address from the address/offset adder, store data from the register file) and the byte-wide data memory.

Parameters:
- I, 32, address width
- N, 8, lane (memory word) width
- R, 6, number of lanes
- STRIDE, 1, address increment between consecutive lanes

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request a vector access; sampled only in IDLE
- is_store  in  1  1 = vector store, 0 = vector load; latched with start
- base_addr  in  I  address of lane 0; latched with start
- store_data  in  R*N  store vector, lane k at bits [k*N+N-1:k*N]; latched with start
- mem_req  out  1  memory transaction request
- mem_we  out  1  write enable, valid while mem_req
- mem_addr  out  I  transaction address
- mem_wd  out  N  write data
- mem_rd  in  N  read data, valid in the cycle mem_ack=1
- mem_ack  in  1  transaction complete this cycle
- load_data  out  R*N  assembled load vector, lane k at [k*N+N-1:k*N]
- busy  out  1  state != IDLE
- stall  out  1  freeze upstream pipeline stages
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, lane counter=0, latched registers cleared.
  - Outputs mem_req=0, mem_we=0, mem_addr=0, mem_wd=0, load_data=0, busy=0, done=0.
  - stall=0 while reset is asserted.
  - Reset mid-transaction aborts immediately, with mem_req dropping asynchronously. The partial load buffer is discarded (cleared to 0).
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If start=1: latch is_store, base_addr and store_data; lane=0; go to ACCESS.
  - stall = start (combinational), so the requesting instruction is frozen in the same cycle.
- ACCESS:
  - mem_req=1.
  - mem_addr = base_q + lane*STRIDE, truncated to I bits (wraps modulo 2^I).
  - mem_we = is_store_q; mem_wd = store_q lane[lane] (0 for loads).
  - stall=1.
  - While mem_ack=0: all outputs hold, with unlimited wait states.
  - On mem_ack=1 for a load: load buffer lane[lane] <= mem_rd.
  - On mem_ack=1 with lane==R-1: go to DONE. Otherwise lane<=lane+1 and stay in ACCESS; the next request is presented back-to-back with no idle cycle.
- DONE:
  - done=1, stall=0, mem_req=0, busy=1.
  - Return to IDLE next cycle.
  - start during DONE is ignored; the requester must re-assert it in IDLE.
- load_data:
  - Drives the load buffer.
  - Updated only by load acks; holds its value through stores and IDLE until the next load overwrites its lanes.
- start is ignored while busy. The latched inputs are immune to changes on is_store, base_addr and store_data after the start cycle.
- mem_ack outside ACCESS is ignored.
- Latency with mem_ack tied high:
  - start at cycle 0; ACCESS in cycles 1..R; done in cycle R+1.
  - Total R+2 cycles, start to IDLE.
- Each extra ack-wait cycle adds exactly one cycle.

Test Plan:
- Load, ack tied 1: base=0x100, mem returns addr[7:0]+1.
  - mem_addr = 0x100..0x105 in cycles 1..6, mem_we=0.
  - done in cycle 7; load_data lanes 5..0 = 06 05 04 03 02 01.
  - stall high in cycles 0..6.
- Store: base=0x20, store_data lanes 5..0 = 0F 0E 0D 0C 0B 0A.
  - Writes 0A@0x20 … 0F@0x25 with mem_we=1.
  - load_data unchanged from the previous test.
- Wait states: ack delayed 2 cycles on lane 3 only.
  - mem_addr, mem_wd and mem_we hold for 3 cycles on lane 3.
  - done arrives at cycle 9.
- Wrap and stride: STRIDE=2, base=0xFFFFFFFC.
  - Addresses FFFFFFFC, FFFFFFFE, 00000000, 00000002, 00000004, 00000006.
- Start while busy: pulse start with different base_addr during ACCESS and during DONE.
  - Ignored; no second sequence; addresses follow the original base.
- Reset mid-op: assert reset=0 asynchronously at lane 2 of a load.
  - mem_req, busy and stall go to 0 immediately; load_data=0.
  - After release, a new start completes normally.

Source files
------------

// File: rtl/vector_mem_seq.sv
// vector_mem_seq: serializes one R-lane vector load or store into R single-lane
// data-memory transactions over a req/ack handshake. While it runs it stalls
// the upstream pipeline, and for loads it gathers the returned lanes into one
// vector for write-back.
module vector_mem_seq #(
    parameter int I      = 32,
    parameter int N      = 8,
    parameter int R      = 6,
    parameter int STRIDE = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           is_store,
    input  logic [I-1:0]   base_addr,
    input  logic [R*N-1:0] store_data,
    output logic           mem_req,
    output logic           mem_we,
    output logic [I-1:0]   mem_addr,
    output logic [N-1:0]   mem_wd,
    input  logic [N-1:0]   mem_rd,
    input  logic           mem_ack,
    output logic [R*N-1:0] load_data,
    output logic           busy,
    output logic           stall,
    output logic           done
);

    localparam int LW = (R > 1) ? $clog2(R) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(R - 1);
    localparam logic [I-1:0]  STRIDE_I  = I'(STRIDE);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [LW-1:0]  lane_q, lane_d;
    logic           isStore_q, isStore_d;
    logic [I-1:0]   addr_q, addr_d;
    logic [R*N-1:0] storeVec_q, storeVec_d;
    logic [R*N-1:0] loadVec_q, loadVec_d;

    // State and datapath registers. Reset is asynchronous so an abort takes
    // effect at once: the state falls back to IDLE and every latched value,
    // including a partially gathered load vector, is discarded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            lane_q     <= '0;
            isStore_q  <= 1'b0;
            addr_q     <= '0;
            storeVec_q <= '0;
            loadVec_q  <= '0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            isStore_q  <= isStore_d;
            addr_q     <= addr_d;
            storeVec_q <= storeVec_d;
            loadVec_q  <= loadVec_d;
        end
    end

    // Next-state logic. The lane address is kept as a running sum stepped by
    // STRIDE on every ack, which gives base + lane*STRIDE modulo 2^I without
    // a multiplier. Inputs are captured only on the accepted start, so later
    // changes on the request bus cannot disturb a sequence in flight.
    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        isStore_d  = isStore_q;
        addr_d     = addr_q;
        storeVec_d = storeVec_q;
        loadVec_d  = loadVec_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    isStore_d  = is_store;
                    addr_d     = base_addr;
                    storeVec_d = store_data;
                    lane_d     = '0;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    if (!isStore_q) begin
                        for (int k = 0; k < R; k++) begin
                            if (lane_q == LW'(k)) begin
                                loadVec_d[k*N +: N] = mem_rd;
                            end
                        end
                    end
                    if (lane_q == LAST_LANE) begin
                        state_d = DONE;
                    end else begin
                        lane_d = lane_q + LW'(1);
                        addr_d = addr_q + STRIDE_I;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode. Memory-side outputs are driven only in ACCESS so the bus
    // is quiet otherwise; stall follows start combinationally in IDLE so the
    // requesting instruction freezes in its own cycle, but never while reset
    // is held.
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        stall    = 1'b0;
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        case (state_q)
            IDLE: begin
                stall = start & reset;
            end
            ACCESS: begin
                mem_req  = 1'b1;
                mem_we   = isStore_q;
                mem_addr = addr_q;
                stall    = 1'b1;
                if (isStore_q) begin
                    for (int k = 0; k < R; k++) begin
                        if (lane_q == LW'(k)) begin
                            mem_wd = storeVec_q[k*N +: N];
                        end
                    end
                end
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    assign load_data = loadVec_q;

endmodule
